// File: rtl/sram_io_ctrl_burst_pkg.sv
// Shared mode codes, state encoding and mode helpers for the serial SRAM bridge.
package sram_io_ctrl_burst_pkg;

  typedef enum logic [1:0] {
    CTRL_SWR = 2'b00,
    CTRL_SRD = 2'b01,
    CTRL_BWR = 2'b10,
    CTRL_BRD = 2'b11
  } ctrl_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SHIFT_HDR  = 3'd1,
    ST_SHIFT_DATA = 3'd2,
    ST_WRITE      = 3'd3,
    ST_READ       = 3'd4,
    ST_READ_CAP   = 3'd5,
    ST_SHIFT_OUT  = 3'd6,
    ST_DONE       = 3'd7
  } state_e;

  function automatic logic is_burst(input ctrl_e m);
    return m[1];
  endfunction

  function automatic logic is_read(input ctrl_e m);
    return m[0];
  endfunction

endpackage

// File: rtl/sram_io_shifter.sv
// Serial-in / parallel-load shift register (LSB first) with a stallable bit counter.
module sram_io_shifter #(
  parameter int W  = 17,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_shift,
  input  logic          i_si,
  input  logic          i_load,
  input  logic [W-1:0]  i_pdata,
  output logic [W-1:0]  o_next,
  output logic          o_lsb,
  output logic [CW-1:0] o_cnt
);

  logic [W-1:0]  r_sr;
  logic [CW-1:0] r_cnt;

  // Value the register takes on a shift edge; lets the parent capture the final bit in the same edge.
  assign o_next = {i_si, r_sr[W-1:1]};
  assign o_lsb  = r_sr[0];
  assign o_cnt  = r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr  <= i_pdata;
      r_cnt <= '0;
    end else begin
      if (i_shift)
        r_sr <= o_next;
      if (i_clr)
        r_cnt <= '0;
      else if (i_shift)
        r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sram_io_ctrl_burst.sv
// Serial host to single-port SRAM bridge: single/burst write and read with serial read-back.
module sram_io_ctrl_burst
  import sram_io_ctrl_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BGN,
  input  logic                  SI,
  input  logic                  LOAD_N,
  input  logic [1:0]            CTRL,
  input  logic [DATA_WIDTH-1:0] PI,
  output logic                  RDY,
  output logic                  D_WE,
  output logic                  CEN,
  output logic                  SO,
  output logic [ADDR_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] PO
);

  localparam int FW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(FW + 1);

  state_e                r_state, w_nxt;
  ctrl_e                 r_mode;
  logic [ADDR_WIDTH-1:0] r_addr, r_a;
  logic [DATA_WIDTH-1:0] r_po;
  logic [LEN_WIDTH-1:0]  r_remain;

  logic [FW-1:0]         w_sh_next;
  logic                  w_sh_lsb;
  logic [CW-1:0]         w_cnt, w_tc;
  logic                  w_shift, w_term, w_last, w_clr, w_load;
  logic [ADDR_WIDTH-1:0] w_hdr_addr, w_addr_inc;
  logic [DATA_WIDTH-1:0] w_hdr_data;

  assign w_shift    = ((r_state == ST_SHIFT_HDR || r_state == ST_SHIFT_DATA) && !LOAD_N)
                    || (r_state == ST_SHIFT_OUT);
  assign w_tc       = (r_state == ST_SHIFT_HDR) ? CW'(FW - 1) : CW'(DATA_WIDTH - 1);
  assign w_term     = w_shift && (w_cnt == w_tc);
  assign w_last     = !is_burst(r_mode) || (r_remain == '0);
  assign w_clr      = (r_state == ST_IDLE) || w_term;
  assign w_load     = (r_state == ST_READ_CAP);
  assign w_hdr_addr = w_sh_next[FW-1:DATA_WIDTH];
  assign w_hdr_data = w_sh_next[DATA_WIDTH-1:0];
  assign w_addr_inc = r_addr + ADDR_WIDTH'(1);

  sram_io_shifter #(.W(FW), .CW(CW)) u_shifter (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clr   (w_clr),
    .i_shift (w_shift),
    .i_si    (SI),
    .i_load  (w_load),
    .i_pdata ({{ADDR_WIDTH{1'b0}}, PI}),
    .o_next  (w_sh_next),
    .o_lsb   (w_sh_lsb),
    .o_cnt   (w_cnt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    RDY   = 1'b0;
    CEN   = 1'b0;
    D_WE  = 1'b0;
    SO    = 1'b0;
    case (r_state)
      ST_IDLE:       if (BGN) w_nxt = ST_SHIFT_HDR;
      ST_SHIFT_HDR:
        if (w_term) begin
          case (r_mode)
            CTRL_SWR: w_nxt = ST_WRITE;
            CTRL_BWR: w_nxt = ST_SHIFT_DATA;
            default:  w_nxt = ST_READ;
          endcase
        end
      ST_SHIFT_DATA: if (w_term) w_nxt = ST_WRITE;
      ST_WRITE: begin
        CEN   = 1'b1;
        D_WE  = 1'b1;
        w_nxt = w_last ? ST_DONE : ST_SHIFT_DATA;
      end
      ST_READ: begin
        CEN   = 1'b1;
        w_nxt = ST_READ_CAP;
      end
      ST_READ_CAP:   w_nxt = ST_SHIFT_OUT;
      ST_SHIFT_OUT: begin
        SO = w_sh_lsb;
        if (w_term) w_nxt = w_last ? ST_DONE : ST_READ;
      end
      ST_DONE:       RDY = 1'b1;
      default:       w_nxt = ST_IDLE;
    endcase
    if (!BGN) w_nxt = ST_IDLE;
  end

  // Datapath updates are gated by BGN so an abort never leaves a pending access behind.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mode   <= CTRL_SWR;
      r_addr   <= '0;
      r_a      <= '0;
      r_po     <= '0;
      r_remain <= '0;
    end else if (BGN) begin
      case (r_state)
        ST_IDLE: r_mode <= ctrl_e'(CTRL);
        ST_SHIFT_HDR:
          if (w_term) begin
            r_addr   <= w_hdr_addr;
            r_remain <= w_hdr_data[LEN_WIDTH-1:0];
            if (r_mode != CTRL_BWR) r_a  <= w_hdr_addr;
            if (r_mode == CTRL_SWR) r_po <= w_hdr_data;
          end
        ST_SHIFT_DATA:
          if (w_term) begin
            r_po <= w_sh_next[FW-1 -: DATA_WIDTH];
            r_a  <= r_addr;
          end
        ST_WRITE:
          if (!w_last) begin
            r_addr   <= w_addr_inc;
            r_remain <= r_remain - LEN_WIDTH'(1);
          end
        ST_SHIFT_OUT:
          if (w_term && !w_last) begin
            r_addr   <= w_addr_inc;
            r_a      <= w_addr_inc;
            r_remain <= r_remain - LEN_WIDTH'(1);
          end
        default: ;
      endcase
    end
  end

  assign A  = r_a;
  assign PO = r_po;

endmodule
